// File: rtl/led_tick_counter.sv
// Pacing stage for the LED shift register: turns synchronised switches into a periodic
// one-cycle valid strobe with a selectable period and a run/hold control.
module led_tick_counter #(
    parameter int unsigned NB_SW        = 4,
    parameter int unsigned NB_COUNTER   = 32,
    parameter int unsigned COUNT_LIMIT0 = 1000000,
    parameter int unsigned COUNT_LIMIT1 = 2000000,
    parameter int unsigned COUNT_LIMIT2 = 4000000,
    parameter int unsigned COUNT_LIMIT3 = 8000000
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic             o_valid,
    output logic             o_run,
    output logic             o_dir
);

    typedef enum logic {
        StIdle,
        StRun
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NB_SW-1:0]        r_sync;
    logic [NB_SW-1:0]        r_sw_s;
    logic [1:0]              r_sel_d;
    logic [NB_COUNTER-1:0]   r_counter;
    logic [NB_COUNTER-1:0]   w_counter_next;
    logic [NB_COUNTER-1:0]   w_limit;
    logic                    r_valid;
    logic                    w_valid_next;
    logic                    r_dir;
    logic                    w_enable;
    logic [1:0]              w_sel;

    assign w_enable = r_sw_s[0];
    assign w_sel    = r_sw_s[2:1];

    always_comb begin
        w_limit = NB_COUNTER'(COUNT_LIMIT0);
        case (w_sel)
            2'b00:   w_limit = NB_COUNTER'(COUNT_LIMIT0);
            2'b01:   w_limit = NB_COUNTER'(COUNT_LIMIT1);
            2'b10:   w_limit = NB_COUNTER'(COUNT_LIMIT2);
            default: w_limit = NB_COUNTER'(COUNT_LIMIT3);
        endcase
    end

    // Priority in RUN: disable, then period change, then terminal count.
    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter;
        w_valid_next   = 1'b0;
        case (r_state)
            StIdle: begin
                w_counter_next = '0;
                if (w_enable) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (!w_enable) begin
                    w_state_next   = StIdle;
                    w_counter_next = '0;
                end else if (w_sel != r_sel_d) begin
                    w_counter_next = '0;
                end else if (r_counter == w_limit) begin
                    w_counter_next = '0;
                    w_valid_next   = 1'b1;
                end else begin
                    w_counter_next = r_counter + NB_COUNTER'(1);
                end
            end
            default: begin
                w_state_next   = StIdle;
                w_counter_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync    <= '0;
            r_sw_s    <= '0;
            r_sel_d   <= 2'b00;
            r_counter <= '0;
            r_valid   <= 1'b0;
            r_dir     <= 1'b0;
            r_state   <= StIdle;
        end else begin
            r_sync    <= i_sw;
            r_sw_s    <= r_sync;
            r_sel_d   <= w_sel;
            r_counter <= w_counter_next;
            r_valid   <= w_valid_next;
            r_dir     <= r_sw_s[3];
            r_state   <= w_state_next;
        end
    end

    assign o_valid = r_valid;
    assign o_run   = (r_state == StRun);
    assign o_dir   = r_dir;

endmodule

// File: tb/tb_led_tick_counter.sv
// Bench for led_tick_counter: strobe edge numbers are queued when switches are driven and
// popped as strobes appear; run/dir levels are checked at fixed edges.
module tb_led_tick_counter;

    logic       clock;
    logic       i_reset;
    logic [3:0] i_sw;
    logic       o_valid;
    logic       o_run;
    logic       o_dir;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int q_exp[$];

    led_tick_counter #(
        .NB_SW        (4),
        .NB_COUNTER   (8),
        .COUNT_LIMIT0 (3),
        .COUNT_LIMIT1 (5),
        .COUNT_LIMIT2 (7),
        .COUNT_LIMIT3 (9)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_sw    (i_sw),
        .o_valid (o_valid),
        .o_run   (o_run),
        .o_dir   (o_dir)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Strobes land every period edges after first_edge, up to and including last_edge.
    task automatic push_strobes(input int first_edge, input int period, input int last_edge);
        for (int t = first_edge + period; t <= last_edge; t += period) begin
            q_exp.push_back(t);
        end
    endtask

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    always @(negedge clock) begin : strobe_mon
        int e;
        if (o_valid) begin
            if (q_exp.size() == 0) begin
                chk("strobe_extra", cyc, -1);
            end else begin
                e = q_exp.pop_front();
                chk("strobe_cycle", cyc, e);
            end
        end
    end

    initial begin
        i_reset = 1'b0;
        i_sw    = 4'b1111;

        // Reset hold with all switches on
        for (int i = 1; i <= 5; i++) begin
            go_to(i);
            chk("rst_valid", int'(o_valid), 0);
            chk("rst_run", int'(o_run), 0);
            chk("rst_dir", int'(o_dir), 0);
        end
        i_reset = 1'b1;
        i_sw    = 4'b0000;
        for (int i = 6; i <= 9; i++) begin
            go_to(i);
            chk("idle_run", int'(o_run), 0);
        end

        // Basic period, limit 3; RUN entered at edge 13
        go_to(10);
        i_sw = 4'b0001;
        push_strobes(13, 4, 32);
        go_to(12);
        chk("en_run_pre", int'(o_run), 0);
        go_to(13);
        chk("en_run", int'(o_run), 1);

        // Select change to limit 9, landing on the would-be strobe edge 33
        go_to(30);
        i_sw = 4'b0111;
        push_strobes(33, 10, 68);

        // Mid-count change to limit 5, cleared at edge 69
        go_to(66);
        i_sw = 4'b0011;
        push_strobes(69, 6, 91);

        // Disable with counter at 2; RUN left at edge 92
        go_to(89);
        i_sw = 4'b0010;
        go_to(91);
        chk("dis_run_pre", int'(o_run), 1);
        go_to(92);
        chk("dis_run", int'(o_run), 0);

        go_to(100);
        chk("sb_empty_dis", q_exp.size(), 0);
        i_sw = 4'b0011;
        push_strobes(103, 6, 144);
        go_to(102);
        chk("reen_run_pre", int'(o_run), 0);
        go_to(103);
        chk("reen_run", int'(o_run), 1);

        // Direction passthrough
        go_to(122);
        i_sw = 4'b1011;
        go_to(124);
        chk("dir_pre", int'(o_dir), 0);
        go_to(125);
        chk("dir_set", int'(o_dir), 1);

        // Async reset while counter == limit; the strobe due at edge 145 must not appear
        go_to(144);
        i_reset = 1'b0;
        #1;
        chk("arst_valid", int'(o_valid), 0);
        chk("arst_run", int'(o_run), 0);
        chk("arst_dir", int'(o_dir), 0);
        go_to(146);
        i_reset = 1'b1;
        push_strobes(149, 6, 170);
        go_to(148);
        chk("rel_run_pre", int'(o_run), 0);
        chk("rel_dir_pre", int'(o_dir), 0);
        go_to(149);
        chk("rel_run", int'(o_run), 1);
        chk("rel_dir", int'(o_dir), 1);

        go_to(171);
        chk("sb_empty_end", q_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
